// File: rtl/run_pkg.sv
// Shared types and defaults for the batch run controller.
package run_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    REQ,
    RUN,
    LOG,
    DONE
  } run_state_t;

  localparam int RST_CYC_DEF = 4;
  localparam int TO_CYC_DEF  = 16'hFFFF;

endpackage

// File: rtl/run_cnt.sv
// Saturating RUN-cycle counter, timeout compare and per-program count storage.
module run_cnt
  import run_pkg::*;
#(
  parameter int NPROG  = 3,
  parameter int PW     = 2,
  parameter int CW     = 16,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_cyc,
  input  logic          en_cyc,
  input  logic          clr_all,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_sel,
  input  logic [PW-1:0] rd_sel,
  output logic [CW-1:0] rd_data,
  output logic          cyc_to
);

  localparam logic [CW-1:0] CYC_MAX = '1;
  localparam logic [CW-1:0] TO_VAL  = CW'(TO_CYC);

  logic [CW-1:0] cyc;
  logic [CW-1:0] cnt_mem [1:NPROG];

  assign cyc_to = (cyc == TO_VAL);

  // Cycle counter: cleared in REQ, counts up during RUN and sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc <= '0;
    end else if (clr_cyc) begin
      cyc <= '0;
    end else if (en_cyc && (cyc != CYC_MAX)) begin
      cyc <= cyc + 1'b1;
    end
  end

  // Count storage: wiped at batch start, written with the live cycle count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= NPROG; i++) cnt_mem[i] <= '0;
    end else if (clr_all) begin
      for (int i = 1; i <= NPROG; i++) cnt_mem[i] <= '0;
    end else begin
      for (int i = 1; i <= NPROG; i++) begin
        if (wr_en && (wr_sel == PW'(i))) cnt_mem[i] <= cyc;
      end
    end
  end

  // Read port: indices outside 1..NPROG read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 1; i <= NPROG; i++) begin
      if (rd_sel == PW'(i)) rd_data = cnt_mem[i];
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Batch run controller: resets the core, requests each program in turn,
// waits for done and records per-program RUN cycle counts.
//
//  state | meaning
//  IDLE  | core held in reset, waiting for start
//  RST   | core reset held for RST_CYC cycles before a program
//  REQ   | one-cycle req pulse to the core, cycle counter cleared
//  RUN   | waiting for a done rising edge, counting cycles
//  LOG   | store count, advance to next program or finish
//  DONE  | batch finished (normal or timeout), core held in reset
module run_ctrl
  import run_pkg::*;
#(
  parameter int NPROG   = 3,
  parameter int PW      = 2,
  parameter int CW      = 16,
  parameter int RST_CYC = RST_CYC_DEF,
  parameter int TO_CYC  = TO_CYC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          core_done,
  output logic          core_rst,
  output logic          core_req,
  output logic [PW-1:0] prog_sel,
  output logic          busy,
  output logic          all_done,
  output logic          timeout,
  input  logic [PW-1:0] cnt_rd_sel,
  output logic [CW-1:0] cnt_rd_data
);

  localparam int            RW       = $clog2(RST_CYC + 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYC - 1);

  run_state_t    state;
  logic          done_q;
  logic          done_rise;
  logic [RW-1:0] rst_cnt;
  logic          cyc_to;
  logic          launch;
  logic          wr_en;

  assign done_rise = core_done & ~done_q;
  assign launch    = ((state == IDLE) || (state == DONE)) && start;
  // A timeout store is suppressed when done rises in the same cycle; LOG stores instead.
  assign wr_en     = (state == LOG) || ((state == RUN) && cyc_to && !done_rise);

  run_cnt #(
    .NPROG (NPROG),
    .PW    (PW),
    .CW    (CW),
    .TO_CYC(TO_CYC)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_cyc(state == REQ),
    .en_cyc (state == RUN),
    .clr_all(launch),
    .wr_en  (wr_en),
    .wr_sel (prog_sel),
    .rd_sel (cnt_rd_sel),
    .rd_data(cnt_rd_data),
    .cyc_to (cyc_to)
  );

  // Sequencing FSM with registered outputs updated alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      core_rst <= 1'b1;
      core_req <= 1'b0;
      prog_sel <= PW'(1);
      busy     <= 1'b0;
      all_done <= 1'b0;
      timeout  <= 1'b0;
      done_q   <= 1'b0;
      rst_cnt  <= '0;
    end else begin
      done_q <= core_done;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RST;
            prog_sel <= PW'(1);
            timeout  <= 1'b0;
            all_done <= 1'b0;
            busy     <= 1'b1;
            core_rst <= 1'b1;
            rst_cnt  <= RST_LOAD;
          end
        end
        RST: begin
          if (rst_cnt == '0) begin
            state    <= REQ;
            core_rst <= 1'b0;
            core_req <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        REQ: begin
          state    <= RUN;
          core_req <= 1'b0;
        end
        RUN: begin
          if (done_rise) begin
            state <= LOG;
          end else if (cyc_to) begin
            state    <= DONE;
            timeout  <= 1'b1;
            all_done <= 1'b1;
            busy     <= 1'b0;
            core_rst <= 1'b1;
          end
        end
        LOG: begin
          if (prog_sel == PW'(NPROG)) begin
            state    <= DONE;
            all_done <= 1'b1;
            busy     <= 1'b0;
            core_rst <= 1'b1;
          end else begin
            state    <= RST;
            prog_sel <= prog_sel + 1'b1;
            core_rst <= 1'b1;
            rst_cnt  <= RST_LOAD;
          end
        end
        default: begin
          state    <= IDLE;
          core_rst <= 1'b1;
          core_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl with a behavioural core model.
module tb_run_ctrl;

  localparam int TO    = 50;
  localparam int NPROG = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic        core_done;
  logic        core_rst;
  logic        core_req;
  logic [1:0]  prog_sel;
  logic        busy;
  logic        all_done;
  logic        timeout;
  logic [1:0]  cnt_rd_sel;
  logic [15:0] cnt_rd_data;

  int checks = 0;
  int errors = 0;

  // core model configuration per program: done rise/fall RUN cycle, high-before-req
  int rise     [1:3];
  int fall     [1:3];
  bit pre_high [1:3];

  // expectations from the reference model
  int exp_cnt [1:3];
  bit exp_to;
  int exp_reqs;

  // observations from the core model
  int req_total = 0;
  int rst_len_q [$];
  int req_base;

  run_ctrl #(
    .NPROG  (NPROG),
    .PW     (2),
    .CW     (16),
    .RST_CYC(4),
    .TO_CYC (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .core_done  (core_done),
    .core_rst   (core_rst),
    .core_req   (core_req),
    .prog_sel   (prog_sel),
    .busy       (busy),
    .all_done   (all_done),
    .timeout    (timeout),
    .cnt_rd_sel (cnt_rd_sel),
    .cnt_rd_data(cnt_rd_data)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Core model: counts RUN cycles after each req and drives core_done.
  initial begin
    int j;
    int p;
    int rst_run;
    bit armed;
    j = 0; p = 1; rst_run = 0; armed = 0;
    core_done = 0;
    forever begin
      @(negedge clk);
      if (core_req) begin
        rst_len_q.push_back(rst_run);
        req_total++;
        rst_run = 0;
        j = 0;
        armed = 1;
        p = (prog_sel >= 1 && prog_sel <= 3) ? int'(prog_sel) : 0;
        core_done = (p != 0) ? pre_high[p] : 1'b0;
      end else if (core_rst) begin
        rst_run++;
        armed = 0;
        core_done = 0;
      end else begin
        rst_run = 0;
        if (armed && p != 0) begin
          j++;
          if (j == fall[p]) core_done = 0;
          if (j == rise[p]) core_done = 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: a program finishes at its done-rise cycle unless that
  // lies beyond TO+1 RUN cycles, in which case the batch aborts with count TO.
  task automatic set_cfg(input int r1, input int r2, input int r3, input bit stuck1);
    rise[1] = r1; rise[2] = r2; rise[3] = r3;
    for (int p = 1; p <= 3; p++) begin
      fall[p] = 0;
      pre_high[p] = 0;
    end
    if (stuck1) begin
      pre_high[1] = 1;
      fall[1] = 5;
    end
    exp_to = 0;
    exp_reqs = 0;
    for (int p = 1; p <= 3; p++) exp_cnt[p] = 0;
    for (int p = 1; p <= 3; p++) begin
      if (!exp_to) begin
        exp_reqs++;
        if (rise[p] != 0 && rise[p] <= TO + 1) begin
          exp_cnt[p] = rise[p];
        end else begin
          exp_cnt[p] = TO;
          exp_to = 1;
        end
      end
    end
  endtask

  task automatic pulse_start();
    req_base = req_total;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic finish_batch(input string tag);
    int len;
    for (int i = 0; i < 3000; i++) begin
      if (all_done) break;
      @(negedge clk);
    end
    chk({tag, "_all_done"}, all_done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_core_rst"}, core_rst, 1);
    chk({tag, "_timeout"}, timeout, exp_to);
    chk({tag, "_reqs"}, req_total - req_base, exp_reqs);
    for (int p = 1; p <= 3; p++) begin
      cnt_rd_sel = 2'(p);
      #1;
      chk($sformatf("%s_cnt%0d", tag, p), cnt_rd_data, exp_cnt[p]);
    end
    cnt_rd_sel = 0;
    #1;
    chk({tag, "_cnt0"}, cnt_rd_data, 0);
    for (int k = 0; k < exp_reqs; k++) begin
      if (req_base + k < rst_len_q.size()) begin
        len = rst_len_q[req_base + k];
        if (k == 0) chk($sformatf("%s_rstlen%0d", tag, k + 1), (len >= 4), 1);
        else        chk($sformatf("%s_rstlen%0d", tag, k + 1), len, 4);
      end
    end
  endtask

  task automatic wait_req(input int want_prog);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (core_req && prog_sel == 2'(want_prog)) break;
    end
    chk($sformatf("req_seen_p%0d", want_prog), core_req, 1);
  endtask

  initial begin
    reset = 0;
    start = 0;
    cnt_rd_sel = 0;
    set_cfg(10, 20, 30, 0);
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_req", core_req, 0);
    chk("rst_prog_sel", prog_sel, 1);
    chk("rst_busy", busy, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_timeout", timeout, 0);
    for (int p = 1; p <= 3; p++) begin
      cnt_rd_sel = 2'(p);
      #1;
      chk($sformatf("rst_cnt%0d", p), cnt_rd_data, 0);
    end
    reset = 1;
    repeat (2) @(negedge clk);
    chk("idle_core_rst", core_rst, 1);

    // basic batch 10/20/30
    set_cfg(10, 20, 30, 0);
    pulse_start();
    chk("start_busy", busy, 1);
    finish_batch("batch");

    // restart from DONE: all_done drops, counts read zero until new LOGs
    pulse_start();
    chk("restart_all_done", all_done, 0);
    chk("restart_busy", busy, 1);
    cnt_rd_sel = 1;
    #1;
    chk("restart_cnt1_clr", cnt_rd_data, 0);
    finish_batch("restart");

    // start during program 1 RUN cycle 7 is ignored
    set_cfg(10, 20, 30, 0);
    pulse_start();
    wait_req(1);
    repeat (7) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("midstart_busy", busy, 1);
    chk("midstart_prog", prog_sel, 1);
    finish_batch("midstart");

    // timeout on program 2, no third request
    set_cfg(10, 0, 30, 0);
    pulse_start();
    finish_batch("timeout");

    // boundary: done on cycle TO+1 wins, done on TO+2 is a timeout
    set_cfg(TO + 1, TO + 2, 5, 0);
    pulse_start();
    finish_batch("bound");

    // done already high through REQ, falls at 5, rises at 8
    set_cfg(8, 20, 30, 1);
    pulse_start();
    finish_batch("stuck");

    // reset during program 2 RUN
    set_cfg(10, 20, 30, 0);
    pulse_start();
    wait_req(2);
    repeat (5) @(negedge clk);
    reset = 0;
    #1;
    chk("midrst_core_rst", core_rst, 1);
    chk("midrst_core_req", core_req, 0);
    chk("midrst_prog_sel", prog_sel, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_all_done", all_done, 0);
    cnt_rd_sel = 1;
    #1;
    chk("midrst_cnt1", cnt_rd_data, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    pulse_start();
    finish_batch("postrst");

    // randomized batches
    for (int n = 0; n < 6; n++) begin
      set_cfg($urandom_range(1, TO + 6), $urandom_range(1, TO + 6), $urandom_range(1, TO + 6), 0);
      pulse_start();
      finish_batch($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Batch run controller that sits directly upstream of the processor top level.
- Holds the core in reset, selects one program at a time (1..NPROG), pulses the core's req, then waits for the core's done.
- Records a per-program cycle count and reports batch completion or timeout to the host/testbench.
- Its outputs drive the core's reset, req and program-select inputs; it consumes the core's done.

Parameters:
- NPROG, 3, number of programs run per batch.
- PW, 2, program-select width; must satisfy 2^PW > NPROG.
- CW, 16, cycle-counter width.
- RST_CYC, 4, cycles core_rst is held high before each program.
- TO_CYC, 16'hFFFF, RUN-state cycle limit before timeout.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-low reset.
- start, in, 1, host request to begin a batch; sampled only in IDLE or DONE.
- core_done, in, 1, level-sensitive done from core.
- core_rst, out, 1, active-high reset to core.
- core_req, out, 1, one-cycle request pulse to core.
- prog_sel, out, PW, current program index, 1..NPROG.
- busy, out, 1, high in every state except IDLE and DONE.
- all_done, out, 1, batch finished (normal completion or timeout).
- timeout, out, 1, sticky; high if the batch was aborted.
- cnt_rd_sel, in, PW, read index for stored counts.
- cnt_rd_data, out, CW, combinational read of count[cnt_rd_sel]; returns 0 if the index is 0 or greater than NPROG.

Behaviour:
- Reset values (reset=0, asynchronous): state=IDLE, core_rst=1, core_req=0, prog_sel=1, busy=0, all_done=0, timeout=0, all counts=0, done_q=0.
- done_q is registered core_done. done_rise = core_done & ~done_q.
- States: IDLE, RST, REQ, RUN, LOG, DONE.
- IDLE:
  - core_rst=1.
  - start=1 -> RST; prog_sel<=1; counts cleared; timeout<=0.
- RST:
  - core_rst=1 for exactly RST_CYC cycles (down-counter), then -> REQ.
- REQ:
  - core_rst=0, core_req=1 for exactly one cycle -> RUN.
  - cyc<=0.
- RUN:
  - core_rst=0; cyc increments every cycle, saturating at 2^CW-1.
  - done_rise -> LOG. Stored count = number of RUN cycles before the done_rise cycle, inclusive of that cycle. Example: done rises on the 3rd RUN cycle -> count=3.
  - core_done already high on RUN entry is not a rise. It is ignored until it falls and rises again.
  - cyc==TO_CYC without done_rise -> count[prog_sel]<=cyc; timeout<=1 -> DONE.
  - done_rise and timeout in the same cycle: done wins -> LOG.
- LOG (one cycle):
  - count[prog_sel]<=cyc.
  - If prog_sel==NPROG -> DONE; else prog_sel<=prog_sel+1 -> RST.
- DONE:
  - all_done=1, core_rst=1, busy=0.
  - start=1 -> behaves as from IDLE (new batch, counts cleared, all_done<=0).
- start while busy is ignored; there is no queueing.
- Outputs core_rst, core_req, busy and all_done are registered (decoded from registered state); no combinational path from inputs to outputs except cnt_rd_data.
- Reset mid-batch: immediate return to reset values; no partial counts are retained.
- Minimum per-program overhead: RST_CYC + 1 (REQ) + 1 (LOG) cycles beyond the RUN count.

Decomposition:
- Shared package run_pkg:
  - state enum run_state_t {IDLE, RST, REQ, RUN, LOG, DONE}.
  - Constants RST_CYC_DEF and TO_CYC_DEF.
- One sub-module, run_cnt: saturating CW-bit cycle counter with clear/enable, timeout compare and the count storage array with read port.
- FSM and edge detect stay in run_ctrl.

Test Plan:
- Batch: reset, start pulse; core model raises done 10, 20, 30 RUN cycles after each req.
  - Expect counts 10/20/30 on cnt_rd_sel=1/2/3.
  - all_done=1, timeout=0.
  - Exactly 3 core_req pulses, each preceded by 4 cycles of core_rst=1.
- Timeout: TO_CYC=50, core never raises done on program 2.
  - Expect count[2]=50, count[3]=0, timeout=1, all_done=1.
  - No third req.
- Stuck-high done: core_done held high through REQ, falls at RUN cycle 5, rises at RUN cycle 8.
  - Expect count=8; no early LOG.
- start during RUN (program 1, cycle 7): ignored; batch proceeds normally with the same counts as the batch scenario.
- Reset mid-batch: assert reset during program 2 RUN.
  - Expect immediately: state IDLE, core_rst=1, prog_sel=1, counts 0, all_done=0.
  - A new start runs the full batch cleanly.
- Restart from DONE: start after a completed batch.
  - all_done drops the next cycle; counts read 0 until the new LOGs; second batch results match the first.
